// File: rtl/load_store_unit.sv
// Load/store unit between an in-order core and a single-port word memory.
// Handles RISC-V B/H/W loads and stores, including read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t        state;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rword_q;

  logic          req_err_c;
  logic [DW-1:0] load_data_c;
  logic [DW-1:0] merged_c;

  // Request legality: encoding, natural alignment and memory bounds.
  always_comb begin
    req_err_c = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_err_c = 1'b0;
      3'b100, 3'b101:         req_err_c = req_we;
      default:                req_err_c = 1'b1;
    endcase
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_err_c = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_err_c = 1'b1;
    if ({2'b00, req_addr[31:2]} >= DW'(MEM_WORDS))
      req_err_c = 1'b1;
  end

  // Lane extraction for loads; f3_q[2] selects zero extension.
  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    case (addr_q[1:0])
      2'b00:   lb = mem_RD[7:0];
      2'b01:   lb = mem_RD[15:8];
      2'b10:   lb = mem_RD[23:16];
      default: lb = mem_RD[31:24];
    endcase
    lh = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    case (f3_q[1:0])
      2'b00:   load_data_c = {{24{lb[7] & ~f3_q[2]}}, lb};
      2'b01:   load_data_c = {{16{lh[15] & ~f3_q[2]}}, lh};
      default: load_data_c = mem_RD;
    endcase
  end

  // Store word: sub-word stores patch the word captured in READ.
  always_comb begin
    merged_c = rword_q;
    case (f3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'b00:   merged_c[7:0]   = wdata_q[7:0];
          2'b01:   merged_c[15:8]  = wdata_q[7:0];
          2'b10:   merged_c[23:16] = wdata_q[7:0];
          default: merged_c[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged_c[31:16] = wdata_q[15:0];
        else           merged_c[15:0]  = wdata_q[15:0];
      end
      default: merged_c = wdata_q;
    endcase
  end

  // Memory port decodes straight from state; reset gates it off in the same cycle.
  assign req_ready = (state == IDLE);
  assign mem_WE    = rst && (state == WRITE);
  assign mem_A     = (rst && (state == READ || state == WRITE)) ? {2'b00, addr_q[31:2]} : '0;
  assign mem_WD    = mem_WE ? merged_c : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rword_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_err_c) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= 1'b1;
            end else if (req_we && req_funct3[1:0] == 2'b10) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            rword_q <= mem_RD;
            state   <= WRITE;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data_c;
            resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-memory model, response scoreboard
// with latency tracking, and a mid-store reset abort.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge, bench preload port.
  logic [31:0] mem [1024];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  assign mem_RD = mem[mem_A[9:0]];
  always @(posedge clk) begin
    if (pre_we)      mem[pre_idx]     <= pre_val;
    else if (mem_WE) mem[mem_A[9:0]] <= mem_WD;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          we_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Write snooper and response scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_WE) begin
      we_cnt++;
      last_wa = mem_A;
      last_wd = mem_WD;
    end
    if (resp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL resp_unexpected: observed resp_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    sb.push_back('{er, ee, cyc + lat - 1});
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL resp_timeout: observed no response expected one within %0d cycles", lat);
      sb.delete();
    end
  endtask

  int we0;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    pre_we = 1'b1; pre_idx = 10'd5; pre_val = 32'h8899AABB;
    @(posedge clk); #1;
    pre_we = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_WE", 32'(mem_WE), 32'd0);
    chk("rst_mem_A", mem_A, 32'd0);
    chk("rst_mem_WD", mem_WD, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Loads from the preset word
    issue(1'b0, 3'b000, 32'h15, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
    issue(1'b0, 3'b100, 32'h15, 32'h0, 32'h000000AA, 1'b0, 2);
    issue(1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8899, 1'b0, 2);
    issue(1'b0, 3'b101, 32'h14, 32'h0, 32'h0000AABB, 1'b0, 2);
    issue(1'b0, 3'b010, 32'h14, 32'h0, 32'h8899AABB, 1'b0, 2);
    chk("idle_mem_A", mem_A, 32'd0);

    // SH: read-modify-write of upper halfword
    we0 = we_cnt;
    issue(1'b1, 3'b001, 32'h16, 32'h00001234, 32'h0, 1'b0, 3);
    chk("sh_we_count", 32'(we_cnt - we0), 32'd1);
    chk("sh_mem_A", last_wa, 32'd5);
    chk("sh_mem_WD", last_wd, 32'h1234AABB);
    chk("sh_mem_word", mem[5], 32'h1234AABB);

    // SW then LW back
    we0 = we_cnt;
    issue(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("sw_we_count", 32'(we_cnt - we0), 32'd1);
    chk("sw_mem_A", last_wa, 32'd16);
    chk("sw_mem_WD", last_wd, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // SB into top byte, then read back
    we0 = we_cnt;
    issue(1'b1, 3'b000, 32'h17, 32'hFFFFFFCC, 32'h0, 1'b0, 3);
    chk("sb_we_count", 32'(we_cnt - we0), 32'd1);
    chk("sb_mem_WD", last_wd, 32'hCC34AABB);
    issue(1'b0, 3'b000, 32'h17, 32'h0, 32'hFFFFFFCC, 1'b0, 2);

    // Rejected accesses
    we0 = we_cnt;
    issue(1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 3'b001, 32'h43, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1, 1);
    issue(1'b0, 3'b101, 32'h15, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 3'b010, 32'h1000, 32'h1, 32'h0, 1'b1, 1);
    chk("err_we_count", 32'(we_cnt - we0), 32'd0);
    issue(1'b0, 3'b010, 32'h14, 32'h0, 32'hCC34AABB, 1'b0, 2);

    // Reset during the WRITE cycle of an SB aborts it
    we0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h14; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_pre_mem_WE", 32'(mem_WE), 32'd1);
    chk("abort_pre_mem_A", mem_A, 32'd5);
    rst = 1'b0;
    #1;
    chk("abort_mem_WE", 32'(mem_WE), 32'd0);
    chk("abort_mem_A", mem_A, 32'd0);
    chk("abort_mem_WD", mem_WD, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_resp_rdata", resp_rdata, 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_we_count", 32'(we_cnt - we0), 32'd0);
    chk("abort_mem_word", mem[5], 32'hCC34AABB);
    issue(1'b0, 3'b100, 32'h14, 32'h0, 32'h000000BB, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected finish before 100000ns");
    $fatal(1, "watchdog");
  end

endmodule
